discrete_sample_reader: RTL and testbench



---
 rtl/discrete_pkg.sv | 13 +
 rtl/audio_strobe_gen.sv | 31 +++
 rtl/discrete_sample_reader.sv | 78 +++++++
 tb/tb_discrete_sample_reader.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/discrete_pkg.sv
// discrete_pkg: shared sample width, limits and saturation for the discrete audio reader.
package discrete_pkg;
    localparam int SIGNAL_WIDTH = 16;
    localparam int WIDE_WIDTH = 20;
    localparam logic signed [SIGNAL_WIDTH-1:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [SIGNAL_WIDTH-1:0] SAMPLE_MIN = 16'sh8000;
    localparam logic signed [WIDE_WIDTH-1:0] WIDE_MAX = 20'sd32767;
    localparam logic signed [WIDE_WIDTH-1:0] WIDE_MIN = -20'sd32768;

    function automatic logic signed [SIGNAL_WIDTH-1:0] saturate(input logic signed [WIDE_WIDTH-1:0] v);
        return v > WIDE_MAX ? SAMPLE_MAX : v < WIDE_MIN ? SAMPLE_MIN : v[SIGNAL_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/audio_strobe_gen.sv
// audio_strobe_gen: phase-accumulator strobe at SAMPLE_RATE out of CLOCK_RATE, one clk wide.
module audio_strobe_gen #(
    parameter int CLOCK_RATE = 1000000,
    parameter int SAMPLE_RATE = 48000
) (
    input  logic clk,
    input  logic I_RSTn,
    output logic audio_clk_en
);
    if (!(SAMPLE_RATE > 0 && SAMPLE_RATE < CLOCK_RATE)) begin : g_bad_rate
        $error("audio_strobe_gen: need 0 < SAMPLE_RATE < CLOCK_RATE");
    end

    logic [31:0] acc;
    logic [32:0] sum;
    logic hit;

    // one spare bit so the comparison cannot be fooled by a 32-bit wrap
    assign sum = {1'b0, acc} + 33'(SAMPLE_RATE);
    assign hit = sum >= 33'(CLOCK_RATE);

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            acc <= '0;
            audio_clk_en <= 1'b0;
        end else begin
            acc <= hit ? 32'(sum - 33'(CLOCK_RATE)) : sum[31:0];
            audio_clk_en <= hit;
        end
    end
endmodule

// File: rtl/discrete_sample_reader.sv
// discrete_sample_reader: strobes a discrete circuit, captures its sample, applies gain/mute
// and queues it in a small FIFO for the consumer, counting samples lost to a full FIFO.
module discrete_sample_reader import discrete_pkg::*; #(
    parameter int CLOCK_RATE = 1000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int GAIN_SHIFT = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic I_RSTn,
    output logic audio_clk_en,
    input  logic signed [15:0] in_sample,
    input  logic mute,
    output logic signed [15:0] out_sample,
    output logic out_valid,
    input  logic out_ready,
    output logic overflow,
    output logic [7:0] drop_count
);
    if (GAIN_SHIFT < 0 || GAIN_SHIFT > 3) begin : g_bad_gain
        $error("discrete_sample_reader: GAIN_SHIFT must be 0..3");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("discrete_sample_reader: FIFO_DEPTH must be a power of two in 2..16");
    end

    localparam int AW = $clog2(FIFO_DEPTH);

    logic capture_pending, push_pending;
    logic signed [SIGNAL_WIDTH-1:0] captured, push_data;
    logic signed [WIDE_WIDTH-1:0] wide;
    logic signed [SIGNAL_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic pop, full, accept, drop;

    audio_strobe_gen #(.CLOCK_RATE(CLOCK_RATE), .SAMPLE_RATE(SAMPLE_RATE)) u_strobe (
        .clk(clk),
        .I_RSTn(I_RSTn),
        .audio_clk_en(audio_clk_en)
    );

    assign wide = {{(WIDE_WIDTH - SIGNAL_WIDTH){captured[SIGNAL_WIDTH-1]}}, captured} << GAIN_SHIFT;
    assign push_data = mute ? '0 : saturate(wide);
    assign out_valid = count != '0;
    assign out_sample = out_valid ? mem[rd_ptr] : '0;
    assign pop = out_valid & out_ready;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    // a pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign accept = push_pending & (~full | pop);
    assign drop = push_pending & full & ~pop;

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            capture_pending <= 1'b0;
            push_pending <= 1'b0;
            captured <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            drop_count <= '0;
        end else begin
            capture_pending <= audio_clk_en;
            push_pending <= capture_pending;
            if (capture_pending) captured <= in_sample;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
            overflow <= drop;
            if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end
endmodule

// File: tb/tb_discrete_sample_reader.sv
// tb_discrete_sample_reader: scoreboard bench driving two readers (gain 0 and gain 2) in lockstep.
module tb_discrete_sample_reader;
    typedef struct packed {logic [15:0] v, e0, e2;} vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mute = 1'b0;
    logic out_ready = 1'b1;
    logic [15:0] in_sample = '0;
    logic en0, en1, v0, v1, ov0, ov1;
    logic [15:0] out0, out1;
    logic [7:0] dc0, dc1;

    logic [15:0] q0[$], q1[$];
    int checks = 0, fails = 0, cyc = 0, ovf = 0, last_en = -1;

    vec_t vecs[10] = '{
        '{16'h1234, 16'h1234, 16'h48D0},
        '{16'h3000, 16'h3000, 16'h7FFF},
        '{16'hD000, 16'hD000, 16'h8000},
        '{16'hFFFB, 16'hFFFB, 16'hFFEC},
        '{16'h0100, 16'h0100, 16'h0400},
        '{16'h8000, 16'h8000, 16'h8000},
        '{16'h1FFF, 16'h1FFF, 16'h7FFC},
        '{16'h2000, 16'h2000, 16'h7FFF},
        '{16'hA5A5, 16'hA5A5, 16'h8000},
        '{16'h0001, 16'h0001, 16'h0004}
    };

    always #5 clk = ~clk;

    discrete_sample_reader u0 (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en0), .in_sample(in_sample), .mute(mute),
        .out_sample(out0), .out_valid(v0), .out_ready(out_ready), .overflow(ov0), .drop_count(dc0)
    );
    discrete_sample_reader #(.GAIN_SHIFT(2)) u2 (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en1), .in_sample(in_sample), .mute(mute),
        .out_sample(out1), .out_valid(v1), .out_ready(out_ready), .overflow(ov1), .drop_count(dc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // monitor: pops the scoreboard whenever a sample is handed over
    always @(negedge clk) begin
        cyc++;
        if (ov0) ovf++;
        chk("twin_match", {en1, v1, ov1, dc1}, {en0, v0, ov0, dc0});
        if (!rst_n) last_en = -1;
        else if (en0) begin
            if (last_en >= 0) chk("strobe_gap", 32'(cyc - last_en == 20 || cyc - last_en == 21), 1);
            last_en = cyc;
        end
        if (!v0) chk("empty_out_zero", out0, 0);
        if (v0 && out_ready) begin
            if (q0.size() == 0) chk("unexpected_pop_g0", 1, 0);
            else chk("data_g0", out0, q0.pop_front());
        end
        if (v1 && out_ready) begin
            if (q1.size() == 0) chk("unexpected_pop_g2", 1, 0);
            else chk("data_g2", out1, q1.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] v, input logic [15:0] e0, input logic [15:0] e2,
                        input bit acc, output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!en0 && k < 100);
        if (!en0) chk("strobe_timeout", 0, 1);
        in_sample = v;
        if (acc) begin
            q0.push_back(e0);
            q1.push_back(e2);
        end
    endtask

    initial begin
        int k, n, t0, base;
        tick(3);
        chk("rst_en", en0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_sample", out0, 0);
        chk("rst_overflow", ov0, 0);
        chk("rst_drops", dc0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].v, vecs[i].e0, vecs[i].e2, 1'b1, k);
            if (i == 0) chk("first_strobe_latency", k, 21);
        end

        n = 0;
        t0 = 0;
        for (int i = 0; i < 600; i++) begin
            send(16'(i), 16'(i), 16'(i * 4), 1'b1, k);
            if (i == 0) t0 = cyc;
            if (cyc - t0 >= 10000) break;
            n++;
        end
        chk("strobes_10ms", 32'(n >= 479 && n <= 481), 1);
        tick(6);
        chk("drained_a", q0.size(), 0);

        out_ready = 1'b0;
        base = ovf;
        for (int i = 0; i < 6; i++) send(16'(16'h1000 + i), 16'(16'h1000 + i), 16'(16'h4000 + 4 * i), i < 4, k);
        tick(5);
        chk("stall_overflows", ovf - base, 2);
        chk("stall_drops", dc0, 2);
        chk("stall_valid", v0, 1);
        chk("stall_held", q0.size(), 4);
        out_ready = 1'b1;
        tick(8);
        chk("drained_b", q0.size(), 0);
        chk("drained_b_valid", v0, 0);

        out_ready = 1'b0;
        base = ovf;
        for (int i = 0; i < 5; i++) send(16'(16'h0200 + i), 16'(16'h0200 + i), 16'(16'h0800 + 4 * i), 1'b1, k);
        tick(2);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        tick(3);
        chk("full_pop_no_overflow", ovf - base, 0);
        chk("full_pop_valid", v0, 1);
        chk("full_pop_left", q0.size(), 4);
        out_ready = 1'b1;
        tick(8);
        chk("drained_c", q0.size(), 0);

        mute = 1'b1;
        send(16'h7000, 16'h0000, 16'h0000, 1'b1, k);
        tick(5);
        send(16'h8001, 16'h0000, 16'h0000, 1'b1, k);
        tick(5);
        mute = 1'b0;
        chk("drained_mute", q0.size(), 0);

        out_ready = 1'b0;
        base = ovf;
        for (int i = 0; i < 304; i++) send(16'(16'h0300 + i), 16'(16'h0300 + i), 16'(16'h0C00 + 4 * i), i < 4, k);
        tick(5);
        chk("sat_overflows", ovf - base, 300);
        chk("sat_drops", dc0, 255);
        out_ready = 1'b1;
        tick(8);
        chk("drained_d", q0.size(), 0);

        out_ready = 1'b0;
        send(16'h0AA0, 16'h0AA0, 16'h2A80, 1'b1, k);
        send(16'h0AA1, 16'h0AA1, 16'h2A84, 1'b1, k);
        send(16'h0BAD, 16'h0BAD, 16'h2EB4, 1'b0, k);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_sample", out0, 0);
        chk("mid_rst_overflow", ov0, 0);
        chk("mid_rst_drops", dc0, 0);
        chk("mid_rst_en", en0, 0);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(16'h0C0D, 16'h0C0D, 16'h3034, 1'b1, k);
        chk("rst_strobe_latency", k, 21);
        tick(6);
        chk("drained_e", q0.size(), 0);
        chk("drained_e_g2", q1.size(), 0);
        chk("final_valid", v0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
